// File: rtl/pwm_capture.sv
// pwm_capture: measures period, high time and integer duty cycle of an async PWM input.
// Optional glitch filter on the synchronised input: define PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture #(
    parameter int WORD_LENGTH   = 8,
    parameter int COUNTER_BITS  = 24,
    parameter int GLITCH_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    pwm_in,
    output logic [WORD_LENGTH-1:0]  duty_cycle,
    output logic [COUNTER_BITS-1:0] period,
    output logic [COUNTER_BITS-1:0] high_time,
    output logic                    valid,
    output logic                    overrun,
    output logic                    stuck
);

    localparam int NW = COUNTER_BITS + 7;
    localparam logic [COUNTER_BITS-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RISE,
        MEASURE
    } state_t;

    state_t state, state_nxt;

    logic [1:0]              sync_q;
    logic                    pwm_s;
    logic                    level;
    logic                    level_d;
    logic                    rise;
    logic [COUNTER_BITS-1:0] cnt, cnt_nxt;
    logic [COUNTER_BITS-1:0] hcnt, hcnt_nxt;
    logic                    latch;
    logic                    ovr_set;
    logic                    tmo;
    logic                    busy;
    logic [2:0]              step;
    logic [6:0]              quo;
    logic [NW-1:0]           rem;
    logic [NW-1:0]           dsh;
    logic                    ge;

    if (WORD_LENGTH < 7 || GLITCH_CYCLES < 1) begin : g_bad_param
        $error("pwm_capture: WORD_LENGTH >= 7 and GLITCH_CYCLES >= 1 required");
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            level_d <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], pwm_in};
            level_d <= level;
        end
    end

    assign pwm_s = sync_q[1];

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    localparam int GW = $clog2(GLITCH_CYCLES + 1);

    logic [GW-1:0] gcnt;
    logic          filt;

    // Level flips only after pwm_s has disagreed for GLITCH_CYCLES cycles in a row
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gcnt <= '0;
            filt <= 1'b0;
        end else if (pwm_s == filt) begin
            gcnt <= '0;
        end else if (gcnt == GW'(GLITCH_CYCLES - 1)) begin
            gcnt <= '0;
            filt <= pwm_s;
        end else begin
            gcnt <= gcnt + 1'b1;
        end
    end

    assign level = filt;
`else
    assign level = pwm_s;
`endif

    assign rise = level & ~level_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            hcnt  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            hcnt  <= hcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hcnt_nxt  = hcnt;
        latch     = 1'b0;
        ovr_set   = 1'b0;
        tmo       = 1'b0;
        if (!start) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            hcnt_nxt  = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_nxt = WAIT_RISE;
                    cnt_nxt   = '0;
                    hcnt_nxt  = '0;
                end
                WAIT_RISE: begin
                    if (rise) begin
                        state_nxt = MEASURE;
                        cnt_nxt   = COUNTER_BITS'(1);
                        hcnt_nxt  = COUNTER_BITS'(1);
                    end else if (cnt == CNT_MAX) begin
                        tmo     = 1'b1;
                        cnt_nxt = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        cnt_nxt  = COUNTER_BITS'(1);
                        hcnt_nxt = COUNTER_BITS'(1);
                        // The result cycle still belongs to the previous division
                        if (busy || valid) begin
                            ovr_set = 1'b1;
                        end else begin
                            latch = 1'b1;
                        end
                    end else if (cnt == CNT_MAX) begin
                        tmo       = 1'b1;
                        state_nxt = WAIT_RISE;
                        cnt_nxt   = '0;
                        hcnt_nxt  = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                        if (level) begin
                            hcnt_nxt = hcnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    assign ge = (rem >= dsh);

    // Quotient is at most 100, so 7 restoring steps with the divisor pre-shifted by 6 suffice
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            duty_cycle <= '0;
            period     <= '0;
            high_time  <= '0;
            valid      <= 1'b0;
            overrun    <= 1'b0;
            stuck      <= 1'b0;
            busy       <= 1'b0;
            step       <= '0;
            quo        <= '0;
            rem        <= '0;
            dsh        <= '0;
        end else begin
            valid <= 1'b0;
            if (!start) begin
                busy    <= 1'b0;
                overrun <= 1'b0;
                stuck   <= 1'b0;
            end else begin
                if (ovr_set) begin
                    overrun <= 1'b1;
                end
                if (latch) begin
                    period    <= cnt;
                    high_time <= hcnt;
                    rem       <= NW'(hcnt) * NW'(100);
                    dsh       <= NW'(cnt) << 6;
                    quo       <= '0;
                    step      <= '0;
                    busy      <= 1'b1;
                end else if (busy) begin
                    if (ge) begin
                        rem <= rem - dsh;
                    end
                    dsh  <= dsh >> 1;
                    quo  <= {quo[5:0], ge};
                    step <= step + 1'b1;
                    if (step == 3'd6) begin
                        busy       <= 1'b0;
                        duty_cycle <= WORD_LENGTH'({quo[5:0], ge});
                        valid      <= 1'b1;
                        stuck      <= 1'b0;
                    end
                end
                if (tmo) begin
                    duty_cycle <= level ? WORD_LENGTH'(100) : '0;
                    period     <= '0;
                    high_time  <= '0;
                    stuck      <= 1'b1;
                    valid      <= 1'b1;
                    busy       <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed checks of pwm_capture with COUNTER_BITS=8.
// Glitch-filter scenario runs when PWM_CAPTURE_GLITCH_FILTER_EN is defined.
`timescale 1ns/1ps
module tb_pwm_capture;

    localparam int CB = 8;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    localparam int FLT = 4;
`else
    localparam int FLT = 0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          pwm_in;
    logic [7:0]    duty_cycle;
    logic [CB-1:0] period;
    logic [CB-1:0] high_time;
    logic          valid;
    logic          overrun;
    logic          stuck;

    int cyc = 0;
    int vcnt = 0;
    int last_vcyc = 0;
    int run = 0;
    int maxrun = 0;
    int n_checks = 0;
    int n_fail = 0;

    pwm_capture #(
        .WORD_LENGTH  (8),
        .COUNTER_BITS (CB),
        .GLITCH_CYCLES(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pwm_in    (pwm_in),
        .duty_cycle(duty_cycle),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .overrun   (overrun),
        .stuck     (stuck)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            vcnt      = vcnt + 1;
            last_vcyc = cyc;
            run       = run + 1;
            if (run > maxrun) maxrun = run;
        end else begin
            run = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pwm_period(input int hi, input int lo);
        pwm_in = 1'b1;
        tick(hi);
        pwm_in = 1'b0;
        tick(lo);
    endtask

    task automatic restart();
        start = 1'b0;
        tick(2);
        start = 1'b1;
        tick(4);
    endtask

    initial begin
        int vs;
        int rk;
        int n0;
        int w;

        reset  = 1'b0;
        start  = 1'b0;
        pwm_in = 1'b0;
        tick(3);
        check("rst_duty", duty_cycle, 0);
        check("rst_period", period, 0);
        check("rst_high", high_time, 0);
        check("rst_valid", valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_stuck", stuck, 0);

        // 25/75 waveform, four rises -> three results
        reset = 1'b1;
        tick(2);
        start = 1'b1;
        tick(4);
        vs = vcnt;
        rk = 0;
        for (int i = 0; i < 4; i++) begin
            rk = cyc + 1;
            pwm_period(25, 75);
        end
        check("t1_results", vcnt - vs, 3);
        check("t1_duty", duty_cycle, 25);
        check("t1_period", period, 100);
        check("t1_high", high_time, 25);
        check("t1_vwidth", maxrun, 1);
        check("t1_latency", last_vcyc - rk, 9 + FLT);
        check("t1_overrun", overrun, 0);
        check("t1_stuck", stuck, 0);

`ifndef PWM_CAPTURE_GLITCH_FILTER_EN
        // 1/2 waveform: period 3, overrun on the second measured edge
        restart();
        for (int i = 0; i < 8; i++) begin
            if (i == 2) check("t2_ovr_early", overrun, 0);
            pwm_period(1, 2);
        end
        tick(15);
        check("t2_overrun", overrun, 1);
        check("t2_period", period, 3);
        check("t2_high", high_time, 1);
        check("t2_duty", duty_cycle, 33);
`endif

        // Held high after one rise -> timeout
        restart();
        vs = vcnt;
        n0 = cyc;
        pwm_in = 1'b1;
        w = 0;
        while (vcnt == vs && w < 300) begin
            tick();
            w++;
        end
        check("t3_tmo_seen", vcnt - vs, 1);
        check("t3_tmo_lat", last_vcyc - n0, 258 + FLT);
        check("t3_stuck", stuck, 1);
        check("t3_duty", duty_cycle, 100);
        check("t3_period", period, 0);
        check("t3_high", high_time, 0);

        pwm_in = 1'b0;
        tick(20);
        for (int i = 0; i < 3; i++) pwm_period(20, 20);
        tick(5);
        check("t3b_stuck", stuck, 0);
        check("t3b_duty", duty_cycle, 50);
        check("t3b_period", period, 40);
        check("t3b_high", high_time, 20);

        // Reset asserted three cycles after a latch, mid-division
        vs = vcnt;
        pwm_in = 1'b1;
        tick(3 + FLT + 3);
        reset = 1'b0;
        #1;
        check("t4_duty", duty_cycle, 0);
        check("t4_period", period, 0);
        check("t4_high", high_time, 0);
        check("t4_valid", valid, 0);
        check("t4_stuck", stuck, 0);
        pwm_in = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(20);
        check("t4_no_valid", vcnt - vs, 0);

`ifndef PWM_CAPTURE_GLITCH_FILTER_EN
        // Build overrun and stuck, then drop start mid-MEASURE
        restart();
        for (int i = 0; i < 6; i++) pwm_period(1, 2);
        w = 0;
        while (stuck !== 1'b1 && w < 400) begin
            tick();
            w++;
        end
        pwm_period(20, 10);
        check("t5_pre_ovr", overrun, 1);
        check("t5_pre_stuck", stuck, 1);
        start = 1'b0;
        tick(2);
        check("t5_clr_ovr", overrun, 0);
        check("t5_clr_stuck", stuck, 0);
        start = 1'b1;
        tick(4);
        vs = vcnt;
        pwm_period(20, 20);
        check("t5_one_rise", vcnt - vs, 0);
        pwm_period(20, 20);
        check("t5_two_rise", vcnt - vs, 1);
        check("t5_duty", duty_cycle, 50);
        check("t5_period", period, 40);
`endif

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
        // 40/60 waveform with 2-cycle glitches in both phases
        restart();
        vs = vcnt;
        for (int i = 0; i < 3; i++) begin
            pwm_period(15, 2);
            pwm_period(23, 20);
            pwm_period(2, 38);
        end
        tick(20);
        check("t6_results", vcnt - vs, 2);
        check("t6_duty", duty_cycle, 40);
        check("t6_period", period, 100);
        check("t6_high", high_time, 40);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
